// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types and defaults (transmitter / receiver).
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int   CLKS_PER_BIT_DEF = 1;
    localparam int   DATA_BITS_DEF    = 8;
    localparam int   STOP_BITS_DEF    = 1;
    localparam logic LINE_IDLE        = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_tick
// Description : Bit-period counter; o_tick marks the last clk of each bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tick
);

    localparam int                 c_CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(CLKS_PER_BIT - 1);

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= (r_count == c_CNT_MAX) ? '0 : r_count + 1'b1;
        end
    end

    assign o_tick = (r_count == c_CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/uart_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : uart_transmitter
// Description : UART frame serialiser with a one-entry holding register.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int DATA_BITS    = DATA_BITS_DEF,
    parameter int STOP_BITS    = STOP_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 TXD,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int                 c_IDX_W     = $clog2(DATA_BITS);
    localparam logic [c_IDX_W-1:0] c_LAST_DATA = c_IDX_W'(DATA_BITS - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_STOP = c_IDX_W'(STOP_BITS - 1);

    tx_state_t            r_state;
    tx_state_t            w_state_nxt;
    logic [DATA_BITS-1:0] r_hold;
    logic                 r_hold_full;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic [c_IDX_W-1:0]   r_bit_idx;
    logic [c_IDX_W-1:0]   w_bit_idx_nxt;
    logic                 r_txd;
    logic                 w_txd_nxt;
    logic                 r_busy;
    logic                 r_done;
    logic                 w_tick;
    logic                 w_accept;
    logic                 w_frame_end;
    logic                 w_load;

    assign w_accept    = tx_valid && !r_hold_full;
    assign w_frame_end = (r_state == STOP) && w_tick && (r_bit_idx == c_LAST_STOP);
    assign w_load      = r_hold_full && ((r_state == IDLE) || w_frame_end);

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk      (clk),
        .rst      (reset),
        .i_clear  (w_load),
        .i_enable (r_state != IDLE),
        .o_tick   (w_tick)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_idx_nxt = r_bit_idx;
        w_txd_nxt     = r_txd;
        case (r_state)
            IDLE: begin
                w_txd_nxt = LINE_IDLE;
                if (r_hold_full) begin
                    w_state_nxt   = START;
                    w_shift_nxt   = r_hold;
                    w_bit_idx_nxt = '0;
                    w_txd_nxt     = 1'b0;
                end
            end
            START: begin
                if (w_tick) begin
                    w_state_nxt   = DATA;
                    w_bit_idx_nxt = '0;
                    w_txd_nxt     = r_shift[0];
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_bit_idx == c_LAST_DATA) begin
                        w_state_nxt   = STOP;
                        w_bit_idx_nxt = '0;
                        w_txd_nxt     = LINE_IDLE;
                    end else begin
                        // Shift right so the next data bit is always at index 1
                        w_bit_idx_nxt = r_bit_idx + 1'b1;
                        w_shift_nxt   = r_shift >> 1;
                        w_txd_nxt     = r_shift[1];
                    end
                end
            end
            STOP: begin
                if (w_frame_end) begin
                    if (r_hold_full) begin
                        w_state_nxt   = START;
                        w_shift_nxt   = r_hold;
                        w_bit_idx_nxt = '0;
                        w_txd_nxt     = 1'b0;
                    end else begin
                        w_state_nxt = IDLE;
                        w_txd_nxt   = LINE_IDLE;
                    end
                end else if (w_tick) begin
                    w_bit_idx_nxt = r_bit_idx + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_txd_nxt   = LINE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_shift     <= '0;
            r_bit_idx   <= '0;
            r_txd       <= LINE_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_txd     <= w_txd_nxt;
            r_busy    <= (w_state_nxt != IDLE);
            r_done    <= w_frame_end;
            if (w_accept) begin
                r_hold      <= tx_data;
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end
        end
    end

    assign tx_ready = !r_hold_full;
    assign TXD      = r_txd;
    assign tx_busy  = r_busy;
    assign tx_done  = r_done;

endmodule
`default_nettype wire

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- Serialises parallel bytes onto the TXD line as asynchronous UART frames: start bit, DATA_BITS data bits LSB-first, STOP_BITS stop bits.
- Sits directly upstream of uart_receiver and drives its RXD input.
- With default parameters, frame timing matches uart_receiver exactly (one clk per bit), so the two blocks loop back without glue.
- A one-entry holding register allows back-to-back frames with no idle gap.

Parameters:
- CLKS_PER_BIT, 1, clk cycles per serial bit; legal range >= 1.
- DATA_BITS, 8, data bits per frame; legal range 5..8.
- STOP_BITS, 1, stop bits per frame; legal range 1..2.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- tx_data  input  DATA_BITS  byte to transmit; sampled on accept.
- tx_valid  input  1  producer offers tx_data.
- tx_ready  output  1  holding register empty; accept = tx_valid && tx_ready at a rising edge.
- TXD  output  1  serial line; idle high.
- tx_busy  output  1  high while a frame is on the line (state != IDLE).
- tx_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high (reset); polarity and synchronicity are fixed.
- Reset values: TXD=1, tx_ready=1, tx_busy=0, tx_done=0. State=IDLE, holding register empty, baud and bit counters cleared.
- Reset mid-frame: TXD returns to 1 immediately (asynchronous). The in-flight byte and any held byte are discarded; no tx_done is issued.
- Holding register:
  - Loaded on accept; tx_ready is !hold_full.
  - A byte is never accepted while the register is full. tx_data is ignored when tx_valid is low.
  - Transfer to the shifter happens at an edge where (state==IDLE) or (last clk of last stop bit), and hold_full. That edge empties the holding register.
  - tx_ready rises in the cycle after the transfer.
- State machine (all outputs registered):
  - IDLE: TXD=1. Leave when hold_full: load shifter, go to START.
  - START: TXD=0 for CLKS_PER_BIT clks, then go to DATA with bit index 0.
  - DATA: TXD=shift[bit] for CLKS_PER_BIT clks per bit. After bit DATA_BITS-1, go to STOP.
  - STOP: TXD=1 for STOP_BITS*CLKS_PER_BIT clks. On the last clk: if hold_full, go to START (back-to-back); else go to IDLE.
- Baud counter: width $clog2(CLKS_PER_BIT) with a minimum of 1. Counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- Latency: an accept at edge N with the shifter idle gives hold_full at edge N. Transfer happens at edge N+1, and TXD=0 from edge N+1.
- Frame length: (1+DATA_BITS+STOP_BITS)*CLKS_PER_BIT clks; default 10.
- tx_done: registered; high exactly one cycle, the cycle after the last stop-bit clk. This holds for back-to-back frames too, where tx_done coincides with the next START.
- tx_busy: high from START entry through the last stop clk; it stays high across back-to-back frames.
- Simultaneous accept and transfer cannot occur, because transfer requires hold_full.

Decomposition:
- Shared package uart_pkg holds:
  - tx state encoding: IDLE, START, DATA, STOP;
  - default constants CLKS_PER_BIT_DEF=1, DATA_BITS_DEF=8, STOP_BITS_DEF=1, shared with uart_receiver;
  - line-level constant LINE_IDLE=1'b1.
- One sub-module is natural: uart_baud_tick. It is a counter that emits a bit-boundary tick every CLKS_PER_BIT clks and is cleared on frame start. It is reusable by the receiver when oversampling is added.

Test Plan:
- Reset: assert reset mid-DATA of 0x3C -> TXD=1 within the same cycle, tx_busy=0, tx_ready=1, no tx_done; after release TXD stays 1 for 20 clks.
- Single frame, defaults: accept 0xA5 at edge N -> TXD sequence from N+1 is 0,1,0,1,0,0,1,0,1,1. tx_done is high at cycle N+11 only.
- Loopback: TXD to uart_receiver RXD; send 0xA5, then 0x5A after idle -> rx_data equals 0xA5, then 0x5A; rx_busy high 9 clks per frame.
- Back-to-back: hold tx_valid with 0x01 then 0xFF -> second start bit immediately follows the first stop bit (no idle clk). tx_busy stays continuous, tx_ready drops after each accept, and two tx_done pulses occur 10 clks apart.
- Parameterised: CLKS_PER_BIT=4, STOP_BITS=2, send 0x80 -> each bit held 4 clks. Frame is 44 clks, MSB (bit 7) is the last data bit and high, and the stop is 8 clks high.
- Backpressure: tx_valid high while hold_full -> tx_ready=0 and tx_data changes are ignored; the held byte is transmitted unchanged.
